// File: rtl/matmul_stream_ctrl.sv
// Streams matA then matB in row-major order into parallel operand registers, pulses start and waits for mm_done.
// It then snapshots mm_result and drains it row-major on a valid/ready port, flagging the last word.
module matmul_stream_ctrl #(
  parameter int FRACTION_WIDTH = 15,
  parameter int BIT_WIDTH      = 32,
  parameter int d1             = 5,
  parameter int d2             = 5,
  parameter int d3             = 5
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  input  logic [BIT_WIDTH-1:0]                   in_data,
  output logic                                   in_ready,
  output logic [d1-1:0][d2-1:0][BIT_WIDTH-1:0]   matA,
  output logic [d2-1:0][d3-1:0][BIT_WIDTH-1:0]   matB,
  output logic                                   start,
  input  logic                                   mm_done,
  input  logic [d1-1:0][d3-1:0][BIT_WIDTH-1:0]   mm_result,
  output logic                                   out_valid,
  output logic [BIT_WIDTH-1:0]                   out_data,
  output logic                                   out_last,
  input  logic                                   out_ready,
  output logic                                   busy
);

  localparam int DMAX = (d1 > d2) ? ((d1 > d3) ? d1 : d3) : ((d2 > d3) ? d2 : d3);
  localparam int CW   = $clog2(DMAX + 1);

  // Data is carried through unchanged, so the fraction width only has to fit inside a word.
  if (FRACTION_WIDTH >= BIT_WIDTH) begin : g_bad_fraction
    $error("FRACTION_WIDTH must be smaller than BIT_WIDTH");
  end

  typedef enum logic [2:0] {
    S_LOAD_A, S_LOAD_B, S_START, S_GUARD, S_WAIT, S_DRAIN
  } state_t;

  state_t                                 r_state, w_state_nxt;
  logic [CW-1:0]                          r_row, r_col, w_row_nxt, w_col_nxt;
  logic [CW-1:0]                          w_row_last, w_col_last;
  logic                                   w_load, w_adv;
  logic [d1-1:0][d2-1:0][BIT_WIDTH-1:0]   r_mat_a;
  logic [d2-1:0][d3-1:0][BIT_WIDTH-1:0]   r_mat_b;
  logic [d1-1:0][d3-1:0][BIT_WIDTH-1:0]   r_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD_A;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // One row/col counter pair walks whichever matrix the current phase owns.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_row_last  = '0;
    w_col_last  = '0;
    w_load      = 1'b0;
    start       = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_load     = 1'b1;
        w_row_last = CW'(d1 - 1);
        w_col_last = CW'(d2 - 1);
      end
      S_LOAD_B: begin
        w_load     = 1'b1;
        w_row_last = CW'(d2 - 1);
        w_col_last = CW'(d3 - 1);
      end
      S_START: begin
        start       = 1'b1;
        w_state_nxt = S_GUARD;
      end
      S_GUARD: w_state_nxt = S_WAIT;
      S_WAIT:  if (mm_done) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        out_valid  = 1'b1;
        w_row_last = CW'(d1 - 1);
        w_col_last = CW'(d3 - 1);
      end
      default: w_state_nxt = S_LOAD_A;
    endcase
    in_ready = rst_n && w_load;
    out_last = out_valid && (r_row == w_row_last) && (r_col == w_col_last);
    w_adv    = (w_load && in_valid) || (out_valid && out_ready);
    if (w_adv) begin
      if (r_col == w_col_last) begin
        w_col_nxt = '0;
        if (r_row == w_row_last) begin
          w_row_nxt = '0;
          case (r_state)
            S_LOAD_A: w_state_nxt = S_LOAD_B;
            S_LOAD_B: w_state_nxt = S_START;
            default:  w_state_nxt = S_LOAD_A;
          endcase
        end else begin
          w_row_nxt = r_row + CW'(1);
        end
      end else begin
        w_col_nxt = r_col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat_a <= '0;
      r_mat_b <= '0;
      r_snap  <= '0;
    end else begin
      for (int i = 0; i < d1; i++)
        for (int j = 0; j < d2; j++)
          if (w_load && in_valid && r_state == S_LOAD_A && r_row == CW'(i) && r_col == CW'(j))
            r_mat_a[i][j] <= in_data;
      for (int i = 0; i < d2; i++)
        for (int j = 0; j < d3; j++)
          if (w_load && in_valid && r_state == S_LOAD_B && r_row == CW'(i) && r_col == CW'(j))
            r_mat_b[i][j] <= in_data;
      if (r_state == S_WAIT && mm_done)
        r_snap <= mm_result;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < d1; i++)
      for (int j = 0; j < d3; j++)
        if (r_row == CW'(i) && r_col == CW'(j))
          out_data = r_snap[i][j];
  end

  assign matA = r_mat_a;
  assign matB = r_mat_b;
  assign busy = !(r_state == S_LOAD_A && r_row == '0 && r_col == '0);

endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Bench for matmul_stream_ctrl: a 2x2x2 instance against a per-cycle behavioural model plus a mock matmul,
// and a 1x3x1 instance exercised directly.
module tb_matmul_stream_ctrl;

  localparam int BW = 32;
  localparam int D1 = 2, D2 = 2, D3 = 2;
  localparam int NA = D1 * D2, NB = D2 * D3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_ready, start, mm_done, out_valid, out_last, out_ready, busy;
  logic [BW-1:0] in_data, out_data;
  logic [D1-1:0][D2-1:0][BW-1:0] matA;
  logic [D2-1:0][D3-1:0][BW-1:0] matB;
  logic [D1-1:0][D3-1:0][BW-1:0] mm_result;

  matmul_stream_ctrl #(.FRACTION_WIDTH(15), .BIT_WIDTH(BW), .d1(D1), .d2(D2), .d3(D3)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .matA(matA), .matB(matB), .start(start), .mm_done(mm_done), .mm_result(mm_result),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  logic iv2, ir2, st2, dn2, ov2, ol2, or2, bz2;
  logic [BW-1:0] id2, od2;
  logic [0:0][2:0][BW-1:0] ma2;
  logic [2:0][0:0][BW-1:0] mb2;
  logic [0:0][0:0][BW-1:0] mr2;

  matmul_stream_ctrl #(.FRACTION_WIDTH(15), .BIT_WIDTH(BW), .d1(1), .d2(3), .d3(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
    .matA(ma2), .matB(mb2), .start(st2), .mm_done(dn2), .mm_result(mr2),
    .out_valid(ov2), .out_data(od2), .out_last(ol2), .out_ready(or2), .busy(bz2)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 loading, 1 computing (k = cycles since load completed), 2 draining.
  int            m_phase = 0, m_nin = 0, m_k = 0;
  logic [31:0]   m_a [D1][D2];
  logic [31:0]   m_b [D2][D3];
  logic [31:0]   m_q [$];
  logic [31:0]   got_q [$];
  int            start_cnt = 0, last_cnt = 0;

  task automatic model_reset();
    m_phase = 0; m_nin = 0; m_k = 0; m_q.delete();
    for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) m_a[i][j] = '0;
    for (int i = 0; i < D2; i++) for (int j = 0; j < D3; j++) m_b[i][j] = '0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_start", 32'(start), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_last", 32'(out_last), 0);
      chk("rst_busy", 32'(busy), 0);
      for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) chk("rst_matA", matA[i][j], 0);
      for (int i = 0; i < D2; i++) for (int j = 0; j < D3; j++) chk("rst_matB", matB[i][j], 0);
      model_reset();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(m_phase == 0));
      chk("start", 32'(start), 32'(m_phase == 1 && m_k == 0));
      chk("out_valid", 32'(out_valid), 32'(m_phase == 2));
      chk("busy", 32'(busy), 32'(!(m_phase == 0 && m_nin == 0)));
      if (m_phase == 2) begin
        chk("out_data", out_data, m_q[0]);
        chk("out_last", 32'(out_last), 32'(m_q.size() == 1));
      end
      for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) chk("matA", matA[i][j], m_a[i][j]);
      for (int i = 0; i < D2; i++) for (int j = 0; j < D3; j++) chk("matB", matB[i][j], m_b[i][j]);
      if (start) start_cnt++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_data);
        if (out_last) last_cnt++;
      end
      // Predict what the coming rising edge does.
      case (m_phase)
        0: if (in_valid) begin
          if (m_nin < NA) m_a[m_nin / D2][m_nin % D2] = in_data;
          else            m_b[(m_nin - NA) / D3][(m_nin - NA) % D3] = in_data;
          m_nin++;
          if (m_nin == NA + NB) begin m_phase = 1; m_k = 0; end
        end
        1: begin
          if (m_k >= 2 && mm_done) begin
            for (int i = 0; i < D1; i++) for (int j = 0; j < D3; j++) m_q.push_back(mm_result[i][j]);
            m_phase = 2;
          end
          m_k++;
        end
        default: if (out_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin m_phase = 0; m_nin = 0; end
        end
      endcase
    end
  end

  function automatic logic [31:0] qdot(input int i, input int j);
    longint acc = 0;
    for (int k = 0; k < D2; k++) acc += longint'($signed(m_a[i][k])) * longint'($signed(m_b[k][j]));
    return 32'(acc >>> 15);
  endfunction

  // Mock matmul: product of the streamed operands, done after mock_lat cycles; in stale mode done
  // stays high with the old result through GUARD and the new result appears in WAIT.
  int mock_lat = 3;
  bit mock_stale = 0;
  logic [D1-1:0][D3-1:0][BW-1:0] prod;
  initial begin
    mm_done = 1'b0; mm_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && start) begin
        for (int i = 0; i < D1; i++) for (int j = 0; j < D3; j++) prod[i][j] = qdot(i, j);
        @(posedge clk); #1;
        if (mock_stale) begin
          @(posedge clk); #1;
        end else begin
          mm_done = 1'b0;
          repeat (mock_lat) @(posedge clk);
          #1;
        end
        mm_result = prod; mm_done = 1'b1;
      end
    end
  end

  task automatic load(input logic [31:0] w [8], input int n, input int mode);
    int i = 0, cyc = 0;
    bit acc;
    while (i < n && cyc < 200) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = w[i];
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("load_timeout", 32'(i), 32'(n));
  endtask

  task automatic drain(input int mode);
    int cyc = 0, rel = -1;
    bit done = 0;
    while (!done && cyc < 400) begin
      if (mode == 1 && rel >= 1 && rel <= 3) out_ready = 1'b0;
      else if (mode == 2)                    out_ready = 1'($urandom_range(0, 1));
      else                                   out_ready = 1'b1;
      @(negedge clk);
      if (out_valid && rel < 0) rel = 0;
      if (out_valid && out_ready && out_last) done = 1;
      @(posedge clk); #1;
      if (rel >= 0) rel++;
      cyc++;
    end
    out_ready = 1'b0;
    chk("drain_timeout", 32'(done), 1);
  endtask

  logic [31:0] w [8];
  logic [31:0] lit [4];
  logic [31:0] w2 [6];
  bit ok;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    iv2 = 1'b0; id2 = '0; dn2 = 1'b0; mr2 = '0; or2 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Identity (Q15) times 1..4
    w = '{32'h8000, 0, 0, 32'h8000, 1, 2, 3, 4};
    lit = '{1, 2, 3, 4};
    got_q.delete(); start_cnt = 0; last_cnt = 0;
    load(w, 8, 0);
    drain(0);
    chk("t1_count", 32'(got_q.size()), 4);
    for (int i = 0; i < 4; i++) chk("t1_word", got_q[i], lit[i]);
    chk("t1_starts", 32'(start_cnt), 1);
    chk("t1_lasts", 32'(last_cnt), 1);

    // Toggled in_valid and a 3-cycle stall mid-drain
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    got_q.delete();
    load(w, 8, 1);
    for (int i = 0; i < D1; i++) for (int j = 0; j < D2; j++) chk("t2_matA", matA[i][j], w[i * D2 + j]);
    for (int i = 0; i < D2; i++) for (int j = 0; j < D3; j++) chk("t2_matB", matB[i][j], w[NA + i * D3 + j]);
    drain(1);
    chk("t2_count", 32'(got_q.size()), 4);

    // Stale done held high from the previous run
    mock_stale = 1;
    w = '{32'h8000, 0, 0, 32'h8000, 5, 6, 7, 8};
    lit = '{5, 6, 7, 8};
    got_q.delete(); start_cnt = 0;
    chk("t3_done_stale", 32'(mm_done), 1);
    load(w, 8, 0);
    drain(0);
    mock_stale = 0;
    chk("t3_count", 32'(got_q.size()), 4);
    for (int i = 0; i < 4; i++) chk("t3_word", got_q[i], lit[i]);
    chk("t3_starts", 32'(start_cnt), 1);

    // Reset after 5 of 8 words, then a fresh load
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    load(w, 5, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    got_q.delete();
    load(w, 8, 2);
    drain(2);
    chk("t4_count", 32'(got_q.size()), 4);

    // Random runs
    for (int r = 0; r < 4; r++) begin
      mock_lat = $urandom_range(1, 4);
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      load(w, 8, 2);
      drain(2);
    end

    // Degenerate 1x3 by 3x1
    w2 = '{32'h8000, 32'h8000, 32'h8000, 5, 6, 7};
    for (int i = 0; i < 6; i++) begin
      iv2 = 1'b1; id2 = w2[i]; ok = 0;
      for (int c = 0; c < 50 && !ok; c++) begin
        @(negedge clk); ok = ir2;
        @(posedge clk); #1;
      end
      chk("d2_load_timeout", 32'(ok), 1);
    end
    iv2 = 1'b0;
    ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); ok = st2;
      if (!ok) begin @(posedge clk); #1; end
    end
    chk("d2_start", 32'(ok), 1);
    for (int j = 0; j < 3; j++) chk("d2_matA", ma2[0][j], w2[j]);
    for (int i = 0; i < 3; i++) chk("d2_matB", mb2[i][0], w2[3 + i]);
    @(posedge clk); #1;
    dn2 = 1'b1; mr2[0][0] = 32'd18;
    @(negedge clk);
    chk("d2_start_pulse", 32'(st2), 0);
    @(posedge clk); #1;
    or2 = 1'b1; ok = 0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); ok = ov2;
      if (ok) begin
        chk("d2_out_data", od2, 32'd18);
        chk("d2_out_last", 32'(ol2), 1);
      end
      @(posedge clk); #1;
    end
    chk("d2_out_seen", 32'(ok), 1);
    @(negedge clk);
    chk("d2_out_valid_drop", 32'(ov2), 0);
    chk("d2_busy_idle", 32'(bz2), 0);
    or2 = 1'b0; dn2 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
